// File: rtl/picorv32_sram_ctrl_pkg.sv
// picorv32_sram_pkg: shared types and bounds for the picorv32 SRAM controller
package picorv32_sram_pkg;
  localparam int SRAM_WORDS = 512;
  localparam int SRAM_DATA_W = 32;
  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 3;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_ERR} state_t;
  function automatic bit latency_ok(int rl);
    return rl >= READ_LATENCY_MIN && rl <= READ_LATENCY_MAX;
  endfunction
endpackage

// File: rtl/picorv32_sram_ctrl_if.sv
// picorv32_sram_ctrl_if: picorv32 native memory port with bus-error response
interface picorv32_sram_ctrl_if;
  import picorv32_sram_pkg::*;
  logic                   mem_valid;
  logic                   mem_instr;
  logic [31:0]            mem_addr;
  logic [SRAM_DATA_W-1:0] mem_wdata;
  logic [3:0]             mem_wstrb;
  logic                   mem_ready;
  logic [SRAM_DATA_W-1:0] mem_rdata;
  logic                   bus_err;
  modport master (output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, input mem_ready, mem_rdata, bus_err);
  modport slave (input mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, output mem_ready, mem_rdata, bus_err);
endinterface

// File: rtl/picorv32_sram_ctrl_stats.sv
// sram_ctrl_stats: wrapping read/write/error completion counters
module sram_ctrl_stats (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inc_rd,
  input  logic        inc_wr,
  input  logic        inc_err,
  output logic [31:0] stat_reads,
  output logic [31:0] stat_writes,
  output logic [31:0] stat_errs
);
  // count one per completed access; natural 32-bit wrap
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      stat_reads  <= '0;
      stat_writes <= '0;
      stat_errs   <= '0;
    end else begin
      stat_reads  <= stat_reads + 32'(inc_rd);
      stat_writes <= stat_writes + 32'(inc_wr);
      stat_errs   <= stat_errs + 32'(inc_err);
    end
endmodule

// File: rtl/picorv32_sram.sv
// picorv32_sram_ctrl: picorv32 memory port to sky130 SRAM port 0 (optional SRAM_CTRL_STATS_EN counters)
module picorv32_sram_ctrl
  import picorv32_sram_pkg::*;
#(
  parameter int          ADDR_WIDTH   = 9,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  picorv32_sram_ctrl_if.slave    bus,
  output logic                   sram_csb0,
  output logic                   sram_web0,
  output logic [3:0]             sram_wmask0,
  output logic [ADDR_WIDTH-1:0]  sram_addr0,
  output logic [SRAM_DATA_W-1:0] sram_din0,
  input  logic [SRAM_DATA_W-1:0] sram_dout0
`ifdef SRAM_CTRL_STATS_EN
  ,
  output logic [31:0]            stat_reads,
  output logic [31:0]            stat_writes,
  output logic [31:0]            stat_errs
`endif
);
  state_t     state;
  logic [1:0] cnt;
  logic       in_range;
  logic       unused_ok;
  assign in_range  = bus.mem_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2];
  assign unused_ok = ^{bus.mem_instr, bus.mem_addr[1:0]};
  if (!latency_ok(READ_LATENCY)) begin : g_bad_latency
    $error("READ_LATENCY out of range 1..3");
  end
  if (BASE_ADDR[ADDR_WIDTH+1:0] != '0) begin : g_bad_base
    $error("BASE_ADDR not aligned to the SRAM window");
  end
  // request sequencer; every output is a register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state         <= S_IDLE;
      cnt           <= '0;
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= '0;
      bus.bus_err   <= 1'b0;
      sram_csb0     <= 1'b1;
      sram_web0     <= 1'b1;
      sram_wmask0   <= '0;
      sram_addr0    <= '0;
      sram_din0     <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.mem_valid) begin
          state <= in_range ? S_ISSUE : S_ERR;
          if (in_range) begin
            sram_csb0   <= 1'b0;
            sram_web0   <= bus.mem_wstrb == 4'd0;
            sram_wmask0 <= bus.mem_wstrb;
            sram_addr0  <= bus.mem_addr[ADDR_WIDTH+1:2];
            sram_din0   <= bus.mem_wdata;
          end
        end
        S_ISSUE: begin
          sram_csb0     <= 1'b1;
          sram_web0     <= 1'b1;
          sram_wmask0   <= '0;
          bus.mem_ready <= !sram_web0;
          state         <= sram_web0 ? S_WAIT : S_DONE;
          cnt           <= 2'(READ_LATENCY - 1);
        end
        S_WAIT: if (cnt != 2'd0) cnt <= cnt - 2'd1;
        else begin
          bus.mem_rdata <= sram_dout0;
          bus.mem_ready <= 1'b1;
          state         <= S_DONE;
        end
        S_ERR: begin
          bus.mem_ready <= 1'b1;
          bus.bus_err   <= 1'b1;
          bus.mem_rdata <= '0;
          state         <= S_DONE;
        end
        default: begin
          bus.mem_ready <= 1'b0;
          bus.bus_err   <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
`ifdef SRAM_CTRL_STATS_EN
  sram_ctrl_stats u_stats (
    .clk         (clk),
    .resetn      (resetn),
    .inc_rd      (state == S_WAIT && cnt == 2'd0),
    .inc_wr      (state == S_ISSUE && !sram_web0),
    .inc_err     (state == S_ERR),
    .stat_reads  (stat_reads),
    .stat_writes (stat_writes),
    .stat_errs   (stat_errs)
  );
`endif
endmodule

// File: tb/tb_picorv32_sram_ctrl.sv
// tb_picorv32_sram_ctrl: scoreboard bench driving READ_LATENCY=1 and =3 controllers in lockstep
module tb_picorv32_sram_ctrl;
  import picorv32_sram_pkg::*;
  typedef struct { logic [31:0] rdata; logic err; int cyc; } exp_t;
  localparam logic [80:0] RST_V = {1'b0, 32'h0, 1'b1, 1'b1, 4'h0, 9'h0, 32'h0, 1'b0};
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  logic v1 = 1'b0, v3 = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0] wstrb = '0;
  logic csb1, web1, csb3, web3;
  logic [3:0] wm1, wm3;
  logic [8:0] a1, a3;
  logic [31:0] din1, dout1, din3, dout3, p3a, p3b;
  logic [31:0] mem1 [512];
  logic [31:0] mem3 [512];
  logic [31:0] model [512];
`ifdef SRAM_CTRL_STATS_EN
  logic [31:0] sr1, sw1, se1, sr3, sw3, se3;
`endif
  picorv32_sram_ctrl_if b1 ();
  picorv32_sram_ctrl_if b3 ();
  assign b1.mem_valid = v1;
  assign b3.mem_valid = v3;
  assign b1.mem_instr = 1'b0;
  assign b3.mem_instr = 1'b0;
  assign b1.mem_addr  = addr;
  assign b3.mem_addr  = addr;
  assign b1.mem_wdata = wdata;
  assign b3.mem_wdata = wdata;
  assign b1.mem_wstrb = wstrb;
  assign b3.mem_wstrb = wstrb;
  picorv32_sram_ctrl #(.READ_LATENCY(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .bus(b1),
    .sram_csb0(csb1), .sram_web0(web1), .sram_wmask0(wm1), .sram_addr0(a1),
    .sram_din0(din1), .sram_dout0(dout1)
`ifdef SRAM_CTRL_STATS_EN
    , .stat_reads(sr1), .stat_writes(sw1), .stat_errs(se1)
`endif
  );
  picorv32_sram_ctrl #(.READ_LATENCY(3)) u_dut3 (
    .clk(clk), .resetn(resetn), .bus(b3),
    .sram_csb0(csb3), .sram_web0(web3), .sram_wmask0(wm3), .sram_addr0(a3),
    .sram_din0(din3), .sram_dout0(dout3)
`ifdef SRAM_CTRL_STATS_EN
    , .stat_reads(sr3), .stat_writes(sw3), .stat_errs(se3)
`endif
  );
  // SRAM models: read data is valid for exactly one window, garbage otherwise
  always @(posedge clk) begin
    if (!csb1 && !web1) for (int i = 0; i < 4; i++) if (wm1[i]) mem1[a1][8*i +: 8] <= din1[8*i +: 8];
    dout1 <= (!csb1 && web1) ? mem1[a1] : 32'hBAD1_BAD1;
  end
  always @(posedge clk) begin
    if (!csb3 && !web3) for (int i = 0; i < 4; i++) if (wm3[i]) mem3[a3][8*i +: 8] <= din3[8*i +: 8];
    p3a   <= (!csb3 && web3) ? mem3[a3] : 32'hBAD3_BAD3;
    p3b   <= p3a;
    dout3 <= p3b;
  end
  int n_tests = 0, n_fail = 0;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  int cyc = 0;
  always @(posedge clk) cyc++;
  exp_t q1[$], q3[$];
  exp_t e1, e3;
  logic pr1 = 1'b0, pr3 = 1'b0;
  int cc1 = 0, cc3 = 0;
  logic exp_web;
  logic [3:0] exp_mask;
  logic [8:0] exp_a;
  logic [31:0] exp_din, exp_last;
  // monitors: SRAM strobes and response pulses against the scoreboard
  always @(negedge clk) begin
    if (resetn) begin
      if (!csb1) begin
        cc1++;
        check("sram1_ctl", {web1, wm1, a1}, {exp_web, exp_mask, exp_a});
        if (!exp_web) check("sram1_din", din1, exp_din);
      end
      if (b1.mem_ready) begin
        check("rdy1_pulse", pr1, 1'b0);
        if (q1.size() == 0) check("rdy1_spurious", 1'b1, 1'b0);
        else begin
          e1 = q1.pop_front();
          check("rsp1", {b1.mem_rdata, b1.bus_err}, {e1.rdata, e1.err});
          check("lat1", cyc, e1.cyc);
        end
      end else check("err1_alone", b1.bus_err, 1'b0);
    end
    pr1 = b1.mem_ready;
  end
  always @(negedge clk) begin
    if (resetn) begin
      if (!csb3) begin
        cc3++;
        check("sram3_ctl", {web3, wm3, a3}, {exp_web, exp_mask, exp_a});
        if (!exp_web) check("sram3_din", din3, exp_din);
      end
      if (b3.mem_ready) begin
        check("rdy3_pulse", pr3, 1'b0);
        if (q3.size() == 0) check("rdy3_spurious", 1'b1, 1'b0);
        else begin
          e3 = q3.pop_front();
          check("rsp3", {b3.mem_rdata, b3.bus_err}, {e3.rdata, e3.err});
          check("lat3", cyc, e3.cyc);
        end
      end else check("err3_alone", b3.bus_err, 1'b0);
    end
    pr3 = b3.mem_ready;
  end
  // issue n identical requests with valid held high; each channel drops valid on its n-th response
  task automatic req(input logic [31:0] ad, input logic [31:0] wd, input logic [3:0] ws, input int n);
    logic inr, rd;
    int l1, l3, k1, k3, s1, s3, t;
    exp_t e;
    inr = ad[31:11] == 21'd0;
    rd = ws == 4'd0;
    addr = ad; wdata = wd; wstrb = ws;
    exp_web = rd; exp_mask = ws; exp_a = ad[10:2]; exp_din = wd;
    if (!inr) exp_last = '0;
    else if (rd) exp_last = model[ad[10:2]];
    else for (int i = 0; i < 4; i++) if (ws[i]) model[ad[10:2]][8*i +: 8] = wd[8*i +: 8];
    l1 = (inr && rd) ? 2 : 1;
    l3 = (inr && rd) ? 4 : 1;
    for (int k = 0; k < n; k++) begin
      e.rdata = exp_last; e.err = !inr;
      e.cyc = cyc + 1 + l1 + k * (l1 + 2); q1.push_back(e);
      e.cyc = cyc + 1 + l3 + k * (l3 + 2); q3.push_back(e);
    end
    s1 = cc1; s3 = cc3; k1 = 0; k3 = 0; t = 0;
    v1 = 1'b1; v3 = 1'b1;
    while ((v1 || v3) && t < 60) begin
      @(negedge clk);
      t++;
      if (v1 && b1.mem_ready) begin k1++; if (k1 == n) v1 = 1'b0; end
      if (v3 && b3.mem_ready) begin k3++; if (k3 == n) v3 = 1'b0; end
    end
    v1 = 1'b0; v3 = 1'b0;
    check("req_done", {k1, k3}, {n, n});
    @(negedge clk);
    check("csb1_pulses", cc1 - s1, inr ? n : 0);
    check("csb3_pulses", cc3 - s3, inr ? n : 0);
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_1"}, {b1.mem_ready, b1.mem_rdata, csb1, web1, wm1, a1, din1, b1.bus_err}, RST_V);
    check({tag, "_3"}, {b3.mem_ready, b3.mem_rdata, csb3, web3, wm3, a3, din3, b3.bus_err}, RST_V);
  endtask
  initial begin
    for (int i = 0; i < 512; i++) model[i] = '0;
    exp_last = '0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    resetn = 1'b1;
    @(negedge clk);
    req(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1);
    req(32'h0000_0010, 32'h0, 4'h0, 1);
    req(32'h0000_0010, 32'h0000_00AA, 4'h1, 1);
    req(32'h0000_0013, 32'h0, 4'h0, 1);
    req(32'h0000_07FC, 32'h1234_5678, 4'hF, 1);
    req(32'h0000_07FC, 32'hCAFE_F00D, 4'hA, 1);
    req(32'h0000_07FC, 32'h0, 4'h0, 1);
    req(32'h0000_1000, 32'h0, 4'h0, 1);
    req(32'h0000_0800, 32'h5555_5555, 4'hF, 1);
    req(32'h0000_0014, 32'h0BAD_CAFE, 4'hF, 1);
    req(32'h0000_0010, 32'h0, 4'h0, 3);
    addr = 32'h10; wstrb = 4'h0; exp_web = 1'b1; exp_mask = 4'h0; exp_a = 9'd4;
    v1 = 1'b1; v3 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check_reset("rst_wait");
    v1 = 1'b0; v3 = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_no_rsp", {q1.size(), q3.size(), b1.mem_ready, b3.mem_ready}, '0);
    exp_last = '0;
`ifdef SRAM_CTRL_STATS_EN
    check("stats_rst", {sr1, sw1, se1, sr3, sw3, se3}, '0);
`endif
    req(32'h0000_0020, 32'h0000_0001, 4'hF, 1);
    req(32'h0000_0024, 32'h0000_0002, 4'hF, 1);
    req(32'h0000_0020, 32'h0, 4'h0, 1);
    req(32'h0000_1800, 32'h0, 4'h0, 1);
`ifdef SRAM_CTRL_STATS_EN
    check("stats_1", {sw1, sr1, se1}, {32'd2, 32'd1, 32'd1});
    check("stats_3", {sw3, sr3, se3}, {32'd2, 32'd1, 32'd1});
`endif
    check("queues_empty", {q1.size(), q3.size()}, '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
endmodule
